bram_graph_loader: RTL and testbench

Sequential BRAM writer that fills the graph BRAM from a valid/ready word stream, starting at address 0 and using consecutive addresses. When the last word is committed it hands the BRAM port to the random-walk engine through `ready`. It replaces the bench-style "write every address, then raise ready" sequence with a synthesizable front end.

---
 rtl/bram_graph_loader.sv | 141 ++++++++++++++
 tb/tb_bram_graph_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_graph_loader.sv
// Streams words into the graph BRAM at addresses 0..N-1, then raises `ready` so the walker can take the port.
// Define LOADER_READBACK_EN to compile in a readback pass that checks the BRAM contents against a load checksum.
//
// state  | meaning
// IDLE   | waiting for the first start
// LOAD   | accepting stream words, one write per handshake
// FLUSH  | last write presented, commits on the exiting edge
// VERIFY | readback sum of addresses 0..N-1 (LOADER_READBACK_EN only)
// DONE   | load complete, walker owns the BRAM port
module bram_graph_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef LOADER_READBACK_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
`endif

  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [2:0]            state;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] checksum;
  logic                  ready_q;
  logic                  handshake;

  assign s_ready    = (state == S_LOAD);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign handshake  = s_valid && s_ready;
  assign word_count = count;
  assign ready      = ready_q;

`ifdef LOADER_READBACK_EN
  // vcyc counts VERIFY edges; read data for address i is sampled when vcyc == i+1
  logic [ADDR_WIDTH:0]   vcyc;
  logic [DATA_WIDTH-1:0] rb_sum;
  logic                  err_q;

  assign err = err_q;
`else
  logic unused_readback;

  assign err             = 1'b0;
  assign unused_readback = ^{data_in, checksum};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      checksum     <= '0;
      ready_q      <= 1'b0;
      address      <= '0;
      write_enable <= 1'b0;
      data_out     <= '0;
`ifdef LOADER_READBACK_EN
      vcyc         <= '0;
      rb_sum       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            ready_q  <= 1'b0;
            count    <= '0;
            checksum <= '0;
`ifdef LOADER_READBACK_EN
            err_q    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          write_enable <= handshake;
          if (handshake) begin
            address  <= count[ADDR_WIDTH-1:0];
            data_out <= s_data;
            count    <= count + 1'b1;
            checksum <= checksum + s_data;
            if (s_last || (count + 1'b1 == FULL)) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          address      <= '0;
          write_enable <= 1'b0;
`ifdef LOADER_READBACK_EN
          state        <= S_VERIFY;
          vcyc         <= '0;
          rb_sum       <= '0;
`else
          state        <= S_DONE;
          ready_q      <= 1'b1;
`endif
        end
`ifdef LOADER_READBACK_EN
        S_VERIFY: begin
          vcyc <= vcyc + 1'b1;
          if (vcyc + 1'b1 < count) begin
            address <= ADDR_WIDTH'(vcyc + 1'b1);
          end
          if ((vcyc != '0) && (vcyc <= count)) begin
            rb_sum <= rb_sum + data_in;
          end
          if (vcyc == count + 1'b1) begin
            err_q   <= (rb_sum != checksum);
            ready_q <= 1'b1;
            address <= '0;
            state   <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_graph_loader.sv
// Directed bench for bram_graph_loader with a registered-read BRAM model; covers both LOADER_READBACK_EN builds.
module tb_bram_graph_loader;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last, s_ready;
  logic [DW-1:0] s_data, data_out, data_in;
  logic [AW-1:0] address;
  logic          write_enable, ready, busy, err;
  logic [AW:0]   word_count;

  int vectors    = 0;
  int miscompares = 0;

  bram_graph_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .address(address),
    .write_enable(write_enable), .data_out(data_out), .data_in(data_in),
    .ready(ready), .busy(busy), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  // BRAM model with a write log; corrupt zeroes read data from address 2
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  logic          corrupt, log_clr;
  int            wr_count = 0;
  logic [AW-1:0] wr_log [0:15];

  always @(posedge clk) begin
    if (log_clr) wr_count <= 0;
    else if (write_enable === 1'b1) begin
      mem[address] <= data_out;
      if (wr_count < 16) wr_log[wr_count] <= address;
      wr_count <= wr_count + 1;
    end
    rd_q      <= mem[address];
    rd_addr_q <= address;
  end

  assign data_in = (corrupt && rd_addr_q == 2) ? '0 : rd_q;

  function automatic int extra(input int n);
`ifdef LOADER_READBACK_EN
    return n + 2;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  // call right after the last handshake edge; ready is due 1 + extra(n) edges later
  task automatic wait_ready(input int n, input string tag);
    int c;
    c = 0;
    while (ready !== 1'b1 && c < 20000) begin
      tick();
      c++;
    end
    check(tag, c, 1 + extra(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_we"}, write_enable, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_word_count"}, word_count, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    corrupt = 1'b0; log_clr = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_s_ready", s_ready, 0);
    check("idle_ready", ready, 0);

    // 16 words 1..16, s_valid held high
    clear_log();
    pulse_start();
    check("t1_s_ready_after_start", s_ready, 1);
    check("t1_busy", busy, 1);
    send(32'd1, 1'b0);
    check("t1_first_addr", address, 0);
    check("t1_first_we", write_enable, 1);
    check("t1_first_data", data_out, 1);
    check("t1_first_count", word_count, 1);
    for (int i = 2; i <= 16; i++) send(DW'(i), i == 16);
    s_valid = 1'b0; s_last = 1'b0;
    check("t1_flush_s_ready", s_ready, 0);
    check("t1_flush_ready", ready, 0);
    check("t1_flush_addr", address, 15);
    check("t1_flush_data", data_out, 16);
    check("t1_flush_we", write_enable, 1);
    wait_ready(16, "t1_ready_latency");
    check("t1_word_count", word_count, 16);
    check("t1_done_addr", address, 0);
    check("t1_done_we", write_enable, 0);
    check("t1_done_busy", busy, 0);
    check("t1_err", err, 0);
    check("t1_writes", wr_count, 16);
    for (int i = 0; i < 16; i++) check($sformatf("t1_mem%0d", i), mem[i], i + 1);

    // 3-word load, then start in DONE drops ready on the same edge
    pulse_start();
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b0);
    send(32'hA3, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(3, "t2_ready_latency");
    check("t2_word_count", word_count, 3);
    pulse_start();
    check("t2_ready_fell", ready, 0);
    check("t2_count_cleared", word_count, 0);
    check("t2_s_ready", s_ready, 1);
    send(32'h55, 1'b0);
    send(32'h66, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(2, "t2b_ready_latency");
    check("t2b_word_count", word_count, 2);
    check("t2b_mem0", mem[0], 32'h55);
    check("t2b_mem1", mem[1], 32'h66);
    check("t2b_mem2", mem[2], 32'hA3);
    check("t2b_mem3", mem[3], 4);

    // s_valid every other cycle; start mid-load must be ignored
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        s_valid = 1'b0; s_last = 1'b0;
        start = (i == 4);
        tick();
        start = 1'b0;
      end
      send(32'h100 + DW'(i), i == 7);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(8, "t3_ready_latency");
    check("t3_word_count", word_count, 8);
    check("t3_writes", wr_count, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_addr%0d", i), wr_log[i], i);
      check($sformatf("t3_mem%0d", i), mem[i], 32'h100 + i);
    end

    // full fill, no s_last, s_valid held high past the end
    clear_log();
    pulse_start();
    hs = 0;
    s_valid = 1'b1; s_last = 1'b0;
    while (s_ready === 1'b1 && hs < DEPTH + 5) begin
      s_data = 32'hDEAD0000 | DW'(hs);
      tick();
      hs++;
    end
    check("t4_handshakes", hs, DEPTH);
    check("t4_word_count", word_count, DEPTH);
    check("t4_s_ready_after", s_ready, 0);
    check("t4_flush_addr", address, DEPTH - 1);
    wait_ready(DEPTH, "t4_ready_latency");
    check("t4_done_addr", address, 0);
    check("t4_done_s_ready", s_ready, 0);
    s_valid = 1'b0;
    tick();
    tick();
    check("t4_writes", wr_count, DEPTH);
    check("t4_mem0", mem[0], 32'hDEAD0000);
    check("t4_mem_last", mem[DEPTH-1], 32'hDEAD1FFF);
    check("t4_final_count", word_count, DEPTH);

    // reset after 5 of 10 words
    pulse_start();
    for (int i = 0; i < 5; i++) send(32'h700 + DW'(i), 1'b0);
    rst = 1'b1;
    s_valid = 1'b1; s_data = 32'h705;
    tick();
    check_all_zero("t5_reset");
    rst = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t5_ready_stays_low", ready, 0);
    check("t5_idle_s_ready", s_ready, 0);
    for (int i = 0; i < 5; i++) check($sformatf("t5_mem%0d", i), mem[i], 32'h700 + i);
    check("t5_mem5_untouched", mem[5], 32'hDEAD0005);

`ifdef LOADER_READBACK_EN
    pulse_start();
    send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b0); send(32'hD, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(4, "rb_ready_latency");
    check("rb_err_clean", err, 0);
    corrupt = 1'b1;
    pulse_start();
    send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b0); send(32'hD, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(4, "rb_corrupt_latency");
    check("rb_err_corrupt", err, 1);
    corrupt = 1'b0;
    pulse_start();
    check("rb_err_cleared_by_start", err, 0);
    send(32'h1, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_ready(1, "rb_single_latency");
    check("rb_single_err", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
